// File: rtl/alu_issue_controller_pkg.sv
// Shared types for the ALU issue stage: ALU operation encodings, RV32I
// opcode/funct constants and the issue FSM state enum.
package alu_issue_controller_pkg;

  typedef enum logic [3:0] {
    ALU_NONE = 4'd0,
    ALU_AND  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_XOR  = 4'd3,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_ADD  = 4'd8,
    ALU_SUB  = 4'd12,
    ALU_SLT  = 4'd13,
    ALU_SLTU = 4'd15
  } alu_control_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // REJECT holds the cycle in which `illegal` is visible before returning to IDLE.
  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXECUTE, S_WRITEBACK, S_REJECT
  } state_t;

endpackage

// File: rtl/alu_issue_controller_regfile.sv
// 32-entry register file: two async read ports, one sync write port, x0 reads zero.
module register_file #(
  parameter int N    = 32,
  parameter int REGS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [4:0]   waddr,
  input  logic [N-1:0] wdata,
  input  logic [4:0]   raddr1,
  input  logic [4:0]   raddr2,
  output logic [N-1:0] rdata1,
  output logic [N-1:0] rdata2
);

  logic [N-1:0] regs [REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/alu_issue_controller.sv
// Four-cycle issue/writeback stage feeding the combinational ALU: accept,
// decode + operand read, execute, writeback into the internal register file.
module alu_issue_controller
  import alu_issue_controller_pkg::*;
#(
  parameter int N    = 32,
  parameter int REGS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [31:0]  instr,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output alu_control_t alu_control,
  input  logic [N-1:0] alu_result,
  input  logic         alu_overflow,
  output logic         wb_valid,
  output logic [4:0]   wb_rd,
  output logic [N-1:0] wb_data,
  output logic         wb_overflow,
  output logic         illegal
);

  state_t       state, state_next;
  logic [31:0]  instr_q;
  logic [N-1:0] rdata1, rdata2;
  logic [N-1:0] imm;
  logic [6:0]   opcode, funct7;
  logic [2:0]   funct3;
  logic         dec_legal;
  logic [N-1:0] dec_b;
  alu_control_t dec_ctrl;

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign funct7 = instr_q[31:25];
  assign imm    = {{(N-12){instr_q[31]}}, instr_q[31:20]};

  register_file #(.N(N), .REGS(REGS)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (state == S_WRITEBACK),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (instr_q[19:15]),
    .raddr2 (instr_q[24:20]),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  // Shift amounts are zero-extended 5-bit values so the ALU never sees b > 31.
  always_comb begin
    dec_legal = 1'b0;
    dec_ctrl  = ALU_NONE;
    dec_b     = (opcode == OPC_OP) ? rdata2 : imm;
    if (opcode == OPC_OP || opcode == OPC_OP_IMM) begin
      dec_legal = 1'b1;
      case (funct3)
        F3_ADD:  dec_ctrl = (opcode == OPC_OP && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
        F3_SLL:  dec_ctrl = ALU_SLL;
        F3_SLT:  dec_ctrl = ALU_SLT;
        F3_SLTU: dec_ctrl = ALU_SLTU;
        F3_XOR:  dec_ctrl = ALU_XOR;
        F3_SR:   dec_ctrl = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
        F3_OR:   dec_ctrl = ALU_OR;
        default: dec_ctrl = ALU_AND;
      endcase
      if (funct3 == F3_SLL || funct3 == F3_SR) begin
        dec_b = {{(N-5){1'b0}}, (opcode == OPC_OP) ? rdata2[4:0] : instr_q[24:20]};
      end
      if (opcode == OPC_OP) begin
        if (funct7 == F7_ALT) dec_legal = (funct3 == F3_ADD) || (funct3 == F3_SR);
        else                  dec_legal = (funct7 == F7_BASE);
      end else if (funct3 == F3_SLL) begin
        dec_legal = (funct7 == F7_BASE);
      end else if (funct3 == F3_SR) begin
        dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (instr_valid) state_next = S_DECODE;
      S_DECODE:    state_next = dec_legal ? S_EXECUTE : S_REJECT;
      S_EXECUTE:   state_next = S_WRITEBACK;
      S_WRITEBACK: state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q     <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= ALU_NONE;
      wb_rd       <= '0;
      wb_data     <= '0;
      wb_overflow <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        S_IDLE: if (instr_valid) instr_q <= instr;
        S_DECODE: begin
          if (dec_legal) begin
            alu_a       <= rdata1;
            alu_b       <= dec_b;
            alu_control <= dec_ctrl;
          end else begin
            illegal <= 1'b1;
          end
        end
        S_EXECUTE: begin
          wb_rd       <= instr_q[11:7];
          wb_data     <= alu_result;
          wb_overflow <= alu_overflow;
        end
        default: ;
      endcase
    end
  end

  assign instr_ready = (state == S_IDLE) && !rst;
  assign wb_valid    = (state == S_WRITEBACK);

endmodule

// File: tb/tb_alu_issue_controller.sv
// Directed bench for alu_issue_controller with a behavioural ALU attached.
module tb_alu_issue_controller;
  import alu_issue_controller_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         instr_valid;
  logic         instr_ready;
  logic [31:0]  instr;
  logic [31:0]  alu_a, alu_b, alu_result;
  alu_control_t alu_control;
  logic         alu_overflow;
  logic         wb_valid, wb_overflow, illegal;
  logic [4:0]   wb_rd;
  logic [31:0]  wb_data;
  logic [31:0]  seen_b;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue_controller #(.N(32), .REGS(32)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_overflow(wb_overflow), .illegal(illegal)
  );

  // Reference ALU, numeric encodings written out independently
  always_comb begin
    logic [31:0] s;
    alu_result   = '0;
    alu_overflow = 1'b0;
    case (4'(alu_control))
      4'd1:  alu_result = alu_a & alu_b;
      4'd2:  alu_result = alu_a | alu_b;
      4'd3:  alu_result = alu_a ^ alu_b;
      4'd5:  alu_result = alu_a << alu_b[4:0];
      4'd6:  alu_result = alu_a >> alu_b[4:0];
      4'd7:  alu_result = 32'($signed(alu_a) >>> alu_b[4:0]);
      4'd8: begin
        s = alu_a + alu_b;
        alu_result   = s;
        alu_overflow = (alu_a[31] == alu_b[31]) && (s[31] != alu_a[31]);
      end
      4'd12: begin
        s = alu_a - alu_b;
        alu_result   = s;
        alu_overflow = (alu_a[31] != alu_b[31]) && (s[31] != alu_a[31]);
      end
      4'd13: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'd15: alu_result = {31'd0, alu_a < alu_b};
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge in IDLE, ends at the negedge of cycle k+4.
  task automatic run_op(input string tag, input logic [31:0] w,
                        input logic [4:0] rd, input logic [31:0] data, input logic ovf);
    instr = w; instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_k1_ready"}, 32'(instr_ready), 32'd0);
    @(negedge clk);
    seen_b = alu_b;
    chk({tag, "_k2_wbv"}, 32'(wb_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_k3_wbv"}, 32'(wb_valid), 32'd1);
    chk({tag, "_k3_rd"}, 32'(wb_rd), 32'(rd));
    chk({tag, "_k3_data"}, wb_data, data);
    chk({tag, "_k3_ovf"}, 32'(wb_overflow), 32'(ovf));
    @(negedge clk);
    chk({tag, "_k4_ready"}, 32'(instr_ready), 32'd1);
    chk({tag, "_k4_wbv"}, 32'(wb_valid), 32'd0);
  endtask

  // Starts at a negedge in IDLE, ends at the negedge of cycle k+3.
  task automatic run_illegal(input string tag, input logic [31:0] w);
    instr = w; instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_k1_ill"}, 32'(illegal), 32'd0);
    @(negedge clk);
    chk({tag, "_k2_ill"}, 32'(illegal), 32'd1);
    chk({tag, "_k2_ready"}, 32'(instr_ready), 32'd0);
    chk({tag, "_k2_wbv"}, 32'(wb_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_k3_ready"}, 32'(instr_ready), 32'd1);
    chk({tag, "_k3_ill"}, 32'(illegal), 32'd0);
    chk({tag, "_k3_wbv"}, 32'(wb_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; seen_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_low", 32'(instr_ready), 32'd0);
    rst = 1'b0; #1;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_ctl", 32'(alu_control), 32'd0);
    chk("rst_wb", {wb_data[29:0], wb_valid, wb_overflow}, 32'd0);
    chk("rst_wb_rd_ill", {26'd0, wb_rd, illegal}, 32'd0);
    @(negedge clk);

    run_op("addi_x1", 32'h00500093, 5'd1, 32'd5, 1'b0);
    run_op("addi_x2", 32'hFFD00113, 5'd2, 32'hFFFFFFFD, 1'b0);
    run_op("sub_x3", 32'h402081B3, 5'd3, 32'd8, 1'b0);
    run_op("addi_x5", 32'h02500293, 5'd5, 32'd37, 1'b0);
    run_op("srl_x6", 32'h00515333, 5'd6, 32'h07FFFFFF, 1'b0);
    chk("srl_alu_b", seen_b, 32'd5);
    run_op("sra_x7", 32'h405153B3, 5'd7, 32'hFFFFFFFF, 1'b0);
    chk("sra_alu_b", seen_b, 32'd5);
    run_op("slt_x8", 32'h00112433, 5'd8, 32'd1, 1'b0);
    run_op("sltu_x9", 32'h001134B3, 5'd9, 32'd0, 1'b0);
    run_op("sltiu_x10", 32'hFFF0B513, 5'd10, 32'd1, 1'b0);
    chk("sltiu_alu_b", seen_b, 32'hFFFFFFFF);
    run_op("slli_x4", 32'h01C09213, 5'd4, 32'h50000000, 1'b0);
    chk("slli_alu_b", seen_b, 32'd28);
    run_op("add_ovf_x14", 32'h00420733, 5'd14, 32'hA0000000, 1'b1);

    run_illegal("ill_zero", 32'h00000000);
    run_illegal("ill_mul", 32'h021081B3);
    run_op("x3_kept", 32'h00018633, 5'd12, 32'd8, 1'b0);

    run_op("addi_x0", 32'h00700013, 5'd0, 32'd7, 1'b0);
    run_op("add_x11_x0", 32'h000005B3, 5'd11, 32'd0, 1'b0);

    // Reset while EXECUTE is in progress.
    instr = 32'h00900793; instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_wbv", 32'(wb_valid), 32'd0);
    chk("midrst_ready", 32'(instr_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_wbv", 32'(wb_valid), 32'd0);
    chk("postrst_ready", 32'(instr_ready), 32'd1);
    run_op("postrst_x1_x15", 32'h00F08833, 5'd16, 32'd0, 1'b0);
    run_op("postrst_x2_x14", 32'h00E108B3, 5'd17, 32'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_controller.md
# alu_issue_controller

Multi-cycle issue/writeback stage directly upstream of the combinational `alu`: accepts one RV32I integer-ALU instruction at a time over a valid/ready handshake, reads operands from an internal register file, drives `alu` operands and `alu_control_t`, captures the result and writes it back. It is the first sequential block in the datapath and the only driver of the `alu` inputs.

## Interface

- `N`, 32: datapath width. Only 32 is supported.
- `REGS`, 32: register count. Fixed; x0 is hardwired zero.

- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `instr_valid`  in  1  upstream has an instruction on `instr`.
- `instr_ready`  out  1  block can accept; high only in IDLE and forced low while `rst` is high.
- `instr`  in  32  RV32I instruction word.
- `alu_a`, `alu_b`  out  N  registered ALU operands.
- `alu_control`  out  alu_control_t  registered ALU operation.
- `alu_result`  in  N  from `alu`.
- `alu_overflow`  in  1  from `alu`.
- `wb_valid`  out  1  one-cycle pulse per retired instruction.
- `wb_rd`  out  5  destination register of the retiring instruction.
- `wb_data`  out  N  value written.
- `wb_overflow`  out  1  captured `alu_overflow` for that instruction.
- `illegal`  out  1  one-cycle pulse for a rejected instruction.

## Operation

- Accepted opcodes: 0110011 (R-type) and 0010011 (I-type). Anything else, or a bad funct7, is illegal.
- R-type (funct7 0000000): ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND. R-type (funct7 0100000): SUB, SRA.
- I-type: ADDI, SLTI, SLTIU, XORI, ORI, ANDI use sign-extended imm[11:0].
- I-type shifts: SLLI needs imm[11:5]=0000000. SRLI/SRAI need 0000000/0100000.
- Shift operand: `alu_b` = rs2[4:0] or shamt, zero-extended. The ALU never sees b>31.
- ALU encodings (`alu_types.sv`): AND=1, OR=2, XOR=3, SLL=5, SRL=6, SRA=7, ADD=8, SUB=12, SLT=13, SLTU=15.
- FSM states:
  - IDLE: `instr_ready`=1. On `instr_valid`, capture `instr` and go to DECODE.
  - DECODE: read rs1/rs2 and decode; register `alu_a`/`alu_b`/`alu_control`. Legal goes to EXECUTE. Illegal pulses `illegal` in the next cycle and returns to IDLE.
  - EXECUTE: ALU settles; capture `alu_result` and `alu_overflow`; go to WRITEBACK.
  - WRITEBACK: `wb_valid`=1; write regfile at end of cycle if rd≠0; go to IDLE.
- Write to x0: `wb_valid` still pulses with `wb_rd`=0 and `wb_data`=ALU result; the register file is unchanged.
- `instr_valid` outside IDLE is ignored; upstream holds it.
- Reset values:
  - State is IDLE.
  - All registers in the file are 0.
  - `alu_a`, `alu_b`, `wb_rd`, `wb_data` are 0.
  - `alu_control` is 0.
  - `wb_valid`, `wb_overflow`, `illegal` are 0.
- Reset mid-operation: the in-flight instruction is dropped. No `wb_valid` and no register write occur.

## Timing

- Handshake completes at edge k. DECODE runs in cycle k+1, EXECUTE in k+2, WRITEBACK in k+3; `wb_valid` is high during k+3.
- `instr_ready` is high again in k+4. Peak throughput is one instruction per 4 cycles.
- Illegal: `illegal` is high in k+2 and `instr_ready` is high in k+3.
- Hazards: none. The register write at the end of WRITEBACK is visible to the next DECODE.

## Structure

- Shared package `rv32i_types.sv`: opcode constants, funct3/funct7 constants, and the FSM state enum. `alu_control_t` stays in `alu_types.sv`.
- Sub-module `register_file`: 32×N, two asynchronous read ports, one synchronous write port with enable. Reads of x0 return 0. Synchronous reset clears all registers.

## Test plan

- Reset, then ADDI x1,x0,5 (0x00500093) → `wb_valid` 3 cycles after accept, `wb_rd`=1, `wb_data`=5; `instr_ready` back in cycle 4.
- ADDI x2,x0,-3 (0xFFD00113), then SUB x3,x1,x2 (0x402081B3) → `wb_data`=0xFFFFFFFD, then 8.
- ADDI x5,x0,37, then SRL x6,x2,x5 → `alu_b`=5, `wb_data`=0x07FFFFFF. SRA x7,x2,x5 → 0xFFFFFFFF.
- SLT x8,x2,x1 → 1; SLTU x9,x2,x1 → 0; SLTIU x10,x1,-1 → 1.
- Instruction 0x00000000, then MUL encoding 0x021081B3 → `illegal` pulses, no `wb_valid`, x3 unchanged.
- ADDI x0,x0,7 → `wb_valid`=1, `wb_rd`=0. A following ADD x11,x0,x0 returns 0.
- Assert `rst` in EXECUTE → no `wb_valid`; afterwards all registers read 0.
